data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dm_resp_pkg.sv | 31 +++
 rtl/dm_array.sv | 37 +++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_resp_pkg.sv
// dm_resp_pkg
// Shared definitions for the data memory responder: FSM state encoding,
// storage geometry, address field positions and the request error rule.
package dm_resp_pkg;

    localparam int DEPTH    = 64;
    localparam int ADDR_LSB = 2;
    localparam int ADDR_MSB = 7;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [ADDR_MSB-ADDR_LSB:0] word_idx_t;

    // A request is rejected when it is not word aligned, falls outside the
    // 256-byte window, or is not exactly one of load/store.
    function automatic logic req_is_error(input logic [ADDR_W-1:0] addr,
                                          input logic              rd,
                                          input logic              wr);
        return (addr[ADDR_LSB-1:0] != '0) ||
               (addr[ADDR_W-1:ADDR_MSB+1] != '0) ||
               (rd == wr);
    endfunction

endpackage

// File: rtl/dm_array.sv
// dm_array
// 64 x 32 word storage: synchronous write, combinational read, asynchronous
// active-low clear of every word.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low clear
//   we_i      write enable (sampled on rising clk)
//   idx_i     word index for both read and write
//   wdata_i   write data
//   rdata_o   combinational read of the word at idx_i
module dm_array
    import dm_resp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  word_idx_t         idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Single-outstanding data memory responder with a fixed number of wait
// states between request acceptance and response.
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   req_valid   request present            req_ready   accepting (IDLE only)
//   mem_rd      load                       mem_wr      store
//   addr        byte address               wr_data     store data
//   resp_valid  response present           resp_ready  response consumed
//   rd_data     load data (0 otherwise)    resp_err    request rejected
//
// state | meaning
// IDLE  | ready for a request; memory effect happens on the acceptance edge
// WAIT  | counting down WAIT_CYCLES wait states
// RESP  | response held until resp_ready
module data_mem_responder
    import dm_resp_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              resp_err
);

    state_t            state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              resp_err_q;
    logic              req_ready_q;
    logic              resp_valid_q;

    logic              accept_d;
    logic              req_err_d;
    logic              mem_we_d;
    word_idx_t         word_idx_d;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_capture_d;

    assign accept_d     = (state_q == IDLE) && req_valid;
    assign req_err_d    = req_is_error(addr, mem_rd, mem_wr);
    assign word_idx_d   = addr[ADDR_MSB:ADDR_LSB];
    assign mem_we_d     = accept_d && !req_err_d && mem_wr;
    assign rd_capture_d = (!req_err_d && mem_rd) ? mem_rdata : '0;

    dm_array u_array (
        .clk     (clk),
        .rst_n   (reset),
        .we_i    (mem_we_d),
        .idx_i   (word_idx_d),
        .wdata_i (wr_data),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            rd_data_q    <= '0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        rd_data_q   <= rd_capture_d;
                        resp_err_q  <= req_err_d;
                        req_ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q    <= WAIT;
                            wait_cnt_q <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == CNT_W'(1)) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        wait_cnt_q   <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        rd_data_q    <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    wait_cnt_q   <= '0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    // The captured result sits in rd_data_q/resp_err_q through WAIT; keep it
    // off the outputs until the response is actually valid.
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign rd_data    = resp_valid_q ? rd_data_q : '0;
    assign resp_err   = resp_valid_q & resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] rd_data;
    logic        resp_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_mem [64];

    data_mem_responder #(.WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .addr       (addr),
        .wr_data    (wr_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .rd_data    (rd_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model_mem[i] = 32'h0;
    endtask

    // Random noise on the request side while the responder is busy.
    task automatic scramble();
        req_valid = 1'($urandom_range(0, 1));
        mem_rd    = 1'($urandom_range(0, 1));
        mem_wr    = 1'($urandom_range(0, 1));
        addr      = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        wr_data   = $urandom;
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold);
        logic        err;
        logic [31:0] exp_data;
        int          cyc;
        bit          seen;
        int          idx;
        err      = (a[1:0] != 2'b00) || (a[31:8] != 24'h0) || (rd == wr);
        idx      = int'(a[7:2]);
        exp_data = 32'h0;
        if (!err && rd) exp_data = model_mem[idx];
        if (!err && wr) model_mem[idx] = d;

        @(negedge clk);
        check("req_ready_in_idle", {31'b0, req_ready}, 32'd1);
        check("resp_valid_in_idle", {31'b0, resp_valid}, 32'd0);
        req_valid  = 1'b1;
        mem_rd     = rd;
        mem_wr     = wr;
        addr       = a;
        wr_data    = d;
        resp_ready = 1'b0;
        @(posedge clk);

        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 32) begin
            @(negedge clk);
            cyc++;
            if (resp_valid === 1'b1) begin
                seen = 1;
            end else begin
                check("rd_data_zero_while_not_valid", rd_data, 32'h0);
                check("resp_err_zero_while_not_valid", {31'b0, resp_err}, 32'd0);
                check("req_ready_low_while_busy", {31'b0, req_ready}, 32'd0);
                scramble();
            end
        end
        check("resp_latency", 32'(cyc), 32'(W + 1));

        if (seen) begin
            check("rd_data", rd_data, exp_data);
            check("resp_err", {31'b0, resp_err}, {31'b0, err});
            for (int i = 0; i < hold; i++) begin
                scramble();
                @(negedge clk);
                check("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
                check("hold_rd_data", rd_data, exp_data);
                check("hold_resp_err", {31'b0, resp_err}, {31'b0, err});
                check("hold_req_ready", {31'b0, req_ready}, 32'd0);
            end
            scramble();
            req_valid  = 1'b1;
            resp_ready = 1'b1;
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            check("post_handshake_req_ready", {31'b0, req_ready}, 32'd1);
            check("post_handshake_resp_valid", {31'b0, resp_valid}, 32'd0);
            check("post_handshake_rd_data", rd_data, 32'h0);
            check("post_handshake_resp_err", {31'b0, resp_err}, 32'd0);
        end else begin
            req_valid  = 1'b0;
            resp_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        clear_model();
        #1;
        check("in_reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("in_reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("in_reset_rd_data", rd_data, 32'h0);
        check("in_reset_resp_err", {31'b0, resp_err}, 32'd0);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_reset_req_ready", {31'b0, req_ready}, 32'd1);
        check("after_reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("after_reset_rd_data", rd_data, 32'h0);
        check("after_reset_resp_err", {31'b0, resp_err}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [5:0]  ix;
        int          r;
        int          k;

        reset      = 1'b0;
        req_valid  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        addr       = 32'h0;
        wr_data    = 32'h0;
        resp_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        do_reset();

        // reset state, load from cleared memory
        txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);

        // store then load, latency W+1
        txn(1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 0);
        txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 0);

        // misaligned and out-of-range loads, memory untouched
        txn(1'b1, 1'b0, 32'h0000_0006, 32'h0, 0);
        txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0);
        txn(1'b0, 1'b1, 32'h0000_0005, 32'h1111_1111, 0);
        txn(1'b0, 1'b1, 32'h0000_0104, 32'h2222_2222, 0);
        txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 0);
        txn(1'b1, 1'b0, 32'h0000_0000, 32'h0, 0);

        // both / neither of rd and wr
        txn(1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_0008, 0);
        txn(1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 0);
        txn(1'b0, 1'b0, 32'h0000_0008, 32'h8765_4321, 0);
        txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, 0);

        // response held with resp_ready low for 5 cycles
        txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 5);
        txn(1'b0, 1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 4);
        txn(1'b1, 1'b0, 32'h0000_00FC, 32'h0, 5);

        // reset during WAIT of a store to 0xC
        @(negedge clk);
        req_valid = 1'b1;
        mem_rd    = 1'b0;
        mem_wr    = 1'b1;
        addr      = 32'h0000_000C;
        wr_data   = 32'h5A5A_C3C3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check("no_resp_after_abort", {31'b0, resp_valid}, 32'd0);
            check("idle_after_abort", {31'b0, req_ready}, 32'd1);
            @(negedge clk);
        end
        txn(1'b1, 1'b0, 32'h0000_000C, 32'h0, 0);
        txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, 0);

        // randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            ix = 6'($urandom_range(0, 15));
            r  = $urandom_range(0, 9);
            if (r == 0)
                a = {24'h0, ix, 2'($urandom_range(1, 3))};
            else if (r == 1)
                a = {24'($urandom_range(1, 32'h00FF_FFFF)), ix, 2'b00};
            else
                a = {24'h0, ix, 2'b00};
            k = $urandom_range(0, 5);
            case (k)
                0:       txn(1'b1, 1'b1, a, $urandom, $urandom_range(0, 3));
                1:       txn(1'b0, 1'b0, a, $urandom, $urandom_range(0, 3));
                2, 3:    txn(1'b1, 1'b0, a, $urandom, $urandom_range(0, 3));
                default: txn(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3));
            endcase
        end

        // read back every word touched by random traffic
        for (int i = 0; i < 16; i++) begin
            ix = 6'(i);
            a  = {24'h0, ix, 2'b00};
            txn(1'b1, 1'b0, a, 32'h0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
